lcd_hd44780_driver: RTL and testbench

- Consumer side of the LCD row byte stream: accepts one character per Escribir/Lista handshake and drives an HD44780-compatible 20x4 panel over the 8-bit parallel bus (RS, RW, E, DB).
- Owns panel power-up initialisation, E-strobe timing and execution-time waits.
- Tracks the cursor column and row, and on row completion issues the Set-DDRAM-address command itself. The RS=0 phase of that command is the end-of-row indication the row register waits on.

---
 rtl/lcd_hd44780_driver.sv | 276 +++++++++++++++++++++++++++
 tb/tb_lcd_hd44780_driver.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_driver.sv
// HD44780 20x4 character LCD driver: power-up init, E-strobe timing, busy waits,
// cursor tracking with automatic DDRAM re-addressing at the end of each row.
module lcd_hd44780_driver #(
    parameter int T_POWERUP = 750000,
    parameter int T_SETUP   = 2,
    parameter int T_PW      = 12,
    parameter int T_HOLD    = 2,
    parameter int T_EXEC    = 2500,
    parameter int T_CLEAR   = 100000,
    parameter int COLS      = 20,
    parameter int ROWS      = 4
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       Escribir,
    input  logic [7:0] Dato_E_LCD,
    input  logic       Limpiar,
    output logic       Lista,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_DB,
    output logic       Init_Done,
    output logic [1:0] Fila
);

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_SETUP   = 3'd1,
        ST_PULSE   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_EXEC    = 3'd4,
        ST_READY   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_INIT  = 2'd0,
        OP_CLEAR = 2'd1,
        OP_CHAR  = 2'd2,
        OP_ADDR  = 2'd3
    } op_t;

    // Counter reload values: a wait of N cycles loads N-1 on entry and exits at zero.
    // POWERUP spends its first cycle arming the counter, hence the extra -1.
    localparam logic [19:0] LD_POWERUP = 20'(T_POWERUP - 2);
    localparam logic [19:0] LD_SETUP   = 20'(T_SETUP - 1);
    localparam logic [19:0] LD_PW      = 20'(T_PW - 1);
    localparam logic [19:0] LD_HOLD    = 20'(T_HOLD - 1);
    localparam logic [19:0] LD_EXEC    = 20'(T_EXEC - 1);
    localparam logic [19:0] LD_CLEAR   = 20'(T_CLEAR - 1);
    localparam logic [4:0]  COL_LAST   = 5'(COLS - 1);
    localparam logic [1:0]  ROW_LAST   = 2'(ROWS - 1);
    localparam logic [2:0]  INIT_LAST  = 3'd6;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        logic [7:0] cmd;
        case (idx)
            3'd0, 3'd1, 3'd2: cmd = 8'h38;
            3'd3:             cmd = 8'h0C;
            3'd4:             cmd = 8'h01;
            3'd5:             cmd = 8'h06;
            3'd6:             cmd = 8'h80;
            default:          cmd = 8'h80;
        endcase
        return cmd;
    endfunction

    function automatic logic [7:0] row_addr_cmd(input logic [1:0] row);
        logic [7:0] cmd;
        case (row)
            2'd0:    cmd = 8'h80;
            2'd1:    cmd = 8'hC0;
            2'd2:    cmd = 8'h94;
            2'd3:    cmd = 8'hD4;
            default: cmd = 8'h80;
        endcase
        return cmd;
    endfunction

    function automatic logic [1:0] next_row(input logic [1:0] row);
        logic [1:0] nxt;
        if (row == ROW_LAST) begin
            nxt = 2'd0;
        end else begin
            nxt = row + 2'd1;
        end
        return nxt;
    endfunction

    state_t      state_r, state_s;
    op_t         op_r, op_s;
    logic [19:0] cnt_r, cnt_s;
    logic [2:0]  idx_r, idx_s;
    logic [4:0]  col_r, col_s;
    logic [1:0]  fila_r, fila_s;
    logic        armed_r, armed_s;
    logic        rs_r, rs_s;
    logic [7:0]  db_r, db_s;
    logic        e_r, e_s;
    logic        lista_r, lista_s;
    logic        init_done_r, init_done_s;
    logic        rw_r;

    // Next-state, counter and bus logic for the whole controller.
    always_comb begin
        state_s     = state_r;
        op_s        = op_r;
        cnt_s       = cnt_r;
        idx_s       = idx_r;
        col_s       = col_r;
        fila_s      = fila_r;
        armed_s     = armed_r;
        rs_s        = rs_r;
        db_s        = db_r;
        lista_s     = 1'b0;
        init_done_s = init_done_r;

        case (state_r)
            ST_POWERUP: begin
                if (!armed_r) begin
                    armed_s = 1'b1;
                    cnt_s   = LD_POWERUP;
                end else if (cnt_r == 20'd0) begin
                    op_s    = OP_INIT;
                    idx_s   = 3'd0;
                    state_s = ST_SETUP;
                    cnt_s   = LD_SETUP;
                    rs_s    = 1'b0;
                    db_s    = init_cmd(3'd0);
                end else begin
                    cnt_s = cnt_r - 20'd1;
                end
            end
            ST_SETUP: begin
                if (cnt_r == 20'd0) begin
                    state_s = ST_PULSE;
                    cnt_s   = LD_PW;
                end else begin
                    cnt_s = cnt_r - 20'd1;
                end
            end
            ST_PULSE: begin
                if (cnt_r == 20'd0) begin
                    state_s = ST_HOLD;
                    cnt_s   = LD_HOLD;
                end else begin
                    cnt_s = cnt_r - 20'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_r != 20'd0) begin
                    cnt_s = cnt_r - 20'd1;
                end else if (!rs_r && (db_r == 8'h01)) begin
                    state_s = ST_EXEC;
                    cnt_s   = LD_CLEAR;
                end else begin
                    state_s = ST_EXEC;
                    cnt_s   = LD_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_r != 20'd0) begin
                    cnt_s = cnt_r - 20'd1;
                end else begin
                    case (op_r)
                        OP_INIT: begin
                            if (idx_r == INIT_LAST) begin
                                init_done_s = 1'b1;
                                col_s       = 5'd0;
                                fila_s      = 2'd0;
                                state_s     = ST_READY;
                            end else begin
                                idx_s   = idx_r + 3'd1;
                                state_s = ST_SETUP;
                                cnt_s   = LD_SETUP;
                                rs_s    = 1'b0;
                                db_s    = init_cmd(idx_r + 3'd1);
                            end
                        end
                        OP_CHAR: begin
                            // Row complete: move to the next row's DDRAM base ourselves.
                            if (col_r == COL_LAST) begin
                                col_s   = 5'd0;
                                fila_s  = next_row(fila_r);
                                op_s    = OP_ADDR;
                                state_s = ST_SETUP;
                                cnt_s   = LD_SETUP;
                                rs_s    = 1'b0;
                                db_s    = row_addr_cmd(next_row(fila_r));
                            end else begin
                                col_s   = col_r + 5'd1;
                                state_s = ST_READY;
                            end
                        end
                        OP_CLEAR: begin
                            col_s   = 5'd0;
                            fila_s  = 2'd0;
                            state_s = ST_READY;
                        end
                        default: begin
                            state_s = ST_READY;
                        end
                    endcase
                end
            end
            ST_READY: begin
                // Clear wins over a simultaneous character; the character waits.
                if (Limpiar) begin
                    op_s    = OP_CLEAR;
                    state_s = ST_SETUP;
                    cnt_s   = LD_SETUP;
                    rs_s    = 1'b0;
                    db_s    = 8'h01;
                end else if (Escribir) begin
                    lista_s = 1'b1;
                    op_s    = OP_CHAR;
                    state_s = ST_SETUP;
                    cnt_s   = LD_SETUP;
                    rs_s    = 1'b1;
                    db_s    = Dato_E_LCD;
                end else begin
                    state_s = ST_READY;
                end
            end
            default: begin
                state_s = ST_POWERUP;
                armed_s = 1'b0;
                cnt_s   = 20'd0;
            end
        endcase

        e_s = (state_s == ST_PULSE);
    end

    // State and output registers; Reset aborts any strobe at once.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_r     <= ST_POWERUP;
            op_r        <= OP_INIT;
            cnt_r       <= 20'd0;
            idx_r       <= 3'd0;
            col_r       <= 5'd0;
            fila_r      <= 2'd0;
            armed_r     <= 1'b0;
            rs_r        <= 1'b0;
            db_r        <= 8'h00;
            e_r         <= 1'b0;
            lista_r     <= 1'b0;
            init_done_r <= 1'b0;
            rw_r        <= 1'b0;
        end else begin
            state_r     <= state_s;
            op_r        <= op_s;
            cnt_r       <= cnt_s;
            idx_r       <= idx_s;
            col_r       <= col_s;
            fila_r      <= fila_s;
            armed_r     <= armed_s;
            rs_r        <= rs_s;
            db_r        <= db_s;
            e_r         <= e_s;
            lista_r     <= lista_s;
            init_done_r <= init_done_s;
            rw_r        <= 1'b0;
        end
    end

    assign Lista     = lista_r;
    assign LCD_RS    = rs_r;
    assign LCD_RW    = rw_r;
    assign LCD_E     = e_r;
    assign LCD_DB    = db_r;
    assign Init_Done = init_done_r;
    assign Fila      = fila_r;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Self-checking bench for lcd_hd44780_driver: a bus monitor records every E strobe,
// a cursor-level model predicts the panel write stream and the bench compares both.
module tb_lcd_hd44780_driver;

    localparam int TP = 20;
    localparam int TS = 2;
    localparam int TW = 3;
    localparam int TH = 2;
    localparam int TE = 10;
    localparam int TC = 30;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       Escribir;
    logic [7:0] Dato;
    logic       Limpiar;
    logic       Lista;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_E;
    logic [7:0] LCD_DB;
    logic       Init_Done;
    logic [1:0] Fila;

    lcd_hd44780_driver #(
        .T_POWERUP(TP), .T_SETUP(TS), .T_PW(TW), .T_HOLD(TH),
        .T_EXEC(TE), .T_CLEAR(TC), .COLS(20), .ROWS(4)
    ) dut (
        .CLK(CLK), .Reset(Reset), .Escribir(Escribir), .Dato_E_LCD(Dato),
        .Limpiar(Limpiar), .Lista(Lista), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_E(LCD_E), .LCD_DB(LCD_DB), .Init_Done(Init_Done), .Fila(Fila)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic rs; logic [7:0] db; int width; int setup; int start; } pulse_t;
    typedef struct { logic rs; logic [7:0] db; } wr_t;

    pulse_t pulse_q[$];
    wr_t    exp_q[$];
    int     lista_q[$];

    logic [7:0] init_cmds [7] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
    logic [7:0] row_base [4] = '{8'h00, 8'h40, 8'h14, 8'h54};

    int n_pass = 0;
    int n_total = 0;
    int m_col = 0;
    int m_row = 0;
    int n_chars = 0;

    int         cyc = 0;
    logic       e_prev = 1'b0;
    logic [8:0] bus_prev = 9'd0;
    int         stable = 0;
    int         width = 0;
    int         hold_left = 0;
    int         glitch_cnt = 0;
    int         hold_viol = 0;
    int         rw_high = 0;
    logic       done_prev = 1'b0;
    int         done_cyc = 0;
    pulse_t     cur;

    // Cycle counter, advanced on the active edge.
    always @(posedge CLK) cyc <= cyc + 1;

    // Bus monitor, sampling on the falling edge.
    always @(negedge CLK) begin
        if (Reset) begin
            e_prev    <= 1'b0;
            hold_left <= 0;
            width     <= 0;
            stable    <= 0;
            bus_prev  <= {LCD_RS, LCD_DB};
            done_prev <= 1'b0;
        end else begin
            e_prev   <= LCD_E;
            bus_prev <= {LCD_RS, LCD_DB};
            stable   <= ({LCD_RS, LCD_DB} == bus_prev) ? stable + 1 : 0;
            if (LCD_RW !== 1'b0) rw_high <= rw_high + 1;
            if (LCD_E && !e_prev) begin
                cur.rs    <= LCD_RS;
                cur.db    <= LCD_DB;
                cur.setup <= ({LCD_RS, LCD_DB} == bus_prev) ? stable + 1 : 0;
                cur.start <= cyc;
                width     <= 1;
            end else if (LCD_E && e_prev) begin
                width <= width + 1;
                if ({LCD_RS, LCD_DB} != {cur.rs, cur.db}) glitch_cnt <= glitch_cnt + 1;
            end else if (!LCD_E && e_prev) begin
                pulse_q.push_back('{rs: cur.rs, db: cur.db, width: width, setup: cur.setup, start: cur.start});
                hold_left <= TH - 1;
                if ({LCD_RS, LCD_DB} != {cur.rs, cur.db}) hold_viol <= hold_viol + 1;
            end else if (hold_left > 0) begin
                hold_left <= hold_left - 1;
                if ({LCD_RS, LCD_DB} != {cur.rs, cur.db}) hold_viol <= hold_viol + 1;
            end
            if (Lista) lista_q.push_back(cyc);
            done_prev <= Init_Done;
            if (Init_Done && !done_prev) done_cyc <= cyc;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic chk_ge(input string tag, input int obs, input int req);
        n_total++;
        assert (obs >= req) n_pass++;
        else $error("FAIL %s observed=%0d required>=%0d", tag, obs, req);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic wait_lista(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick(1);
            if (Lista === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_e(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick(1);
            if (LCD_E === 1'b1) ok = 1'b1;
        end
    endtask

    // Cursor model: one data write per character, address command after every 20th.
    task automatic model_char(input logic [7:0] b);
        exp_q.push_back('{rs: 1'b1, db: b});
        n_chars++;
        m_col++;
        if (m_col == 20) begin
            m_col = 0;
            m_row = (m_row + 1) % 4;
            exp_q.push_back('{rs: 1'b0, db: 8'h80 | row_base[m_row]});
        end
    endtask

    task automatic send_char(input logic [7:0] b);
        bit ok;
        Escribir = 1'b1;
        Dato = b;
        wait_lista(ok);
        chk_eq("lista_seen", 32'(ok), 32'd1);
        if (ok) model_char(b);
        Escribir = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        int n;
        for (int i = 0; i < 3000 && pulse_q.size() < exp_q.size(); i++) tick(1);
        tick(45);
        chk_eq({tag, "_count"}, 32'(pulse_q.size()), 32'(exp_q.size()));
        n = (pulse_q.size() < exp_q.size()) ? pulse_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk_eq({tag, "_rs"}, 32'(pulse_q[i].rs), 32'(exp_q[i].rs));
            chk_eq({tag, "_db"}, 32'(pulse_q[i].db), 32'(exp_q[i].db));
            chk_eq({tag, "_width"}, 32'(pulse_q[i].width), 32'(TW));
            chk_ge({tag, "_setup"}, pulse_q[i].setup, TS);
        end
        pulse_q.delete();
        exp_q.delete();
    endtask

    task automatic check_lista();
        chk_eq("lista_count", 32'(lista_q.size()), 32'(n_chars));
        for (int i = 1; i < lista_q.size(); i++)
            chk_ge("lista_spacing", lista_q[i] - lista_q[i-1], TS + TW + TH + TE + 1);
        lista_q.delete();
        n_chars = 0;
    endtask

    task automatic do_init_check();
        int c0;
        Reset = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 2000 && Init_Done !== 1'b1; i++) tick(1);
        chk_eq("init_done", 32'(Init_Done), 32'd1);
        chk_eq("init_fila", 32'(Fila), 32'd0);
        chk_eq("init_count", 32'(pulse_q.size()), 32'd7);
        for (int i = 0; i < 7 && i < pulse_q.size(); i++) begin
            chk_eq("init_rs", 32'(pulse_q[i].rs), 32'd0);
            chk_eq("init_db", 32'(pulse_q[i].db), 32'(init_cmds[i]));
            chk_eq("init_width", 32'(pulse_q[i].width), 32'(TW));
            chk_ge("init_setup", pulse_q[i].setup, TS);
            if (i == 0)
                chk_eq("init_powerup", 32'(pulse_q[0].start - c0), 32'(TP + TS));
            else
                chk_eq("init_gap", 32'(pulse_q[i].start - pulse_q[i-1].start),
                       32'((init_cmds[i-1] == 8'h01) ? TW + TH + TC + TS : TW + TH + TE + TS));
        end
        if (pulse_q.size() == 7)
            chk_eq("init_done_time", 32'(done_cyc - pulse_q[6].start), 32'(TW + TH + TE));
        pulse_q.delete();
        m_col = 0;
        m_row = 0;
    endtask

    initial begin
        bit         ok;
        logic [7:0] d;
        int         req;
        int         n0;

        Reset = 1'b1;
        Escribir = 1'b0;
        Limpiar = 1'b0;
        Dato = 8'h00;
        tick(3);
        chk_eq("rst_lista", 32'(Lista), 32'd0);
        chk_eq("rst_rs", 32'(LCD_RS), 32'd0);
        chk_eq("rst_rw", 32'(LCD_RW), 32'd0);
        chk_eq("rst_e", 32'(LCD_E), 32'd0);
        chk_eq("rst_db", 32'(LCD_DB), 32'd0);
        chk_eq("rst_init_done", 32'(Init_Done), 32'd0);
        chk_eq("rst_fila", 32'(Fila), 32'd0);

        do_init_check();

        // Single character, then a plain clear to home the cursor.
        send_char(8'h41);
        tick(1);
        chk_eq("lista_one_cycle", 32'(Lista), 32'd0);
        check_writes("single");
        Limpiar = 1'b1;
        tick(1);
        Limpiar = 1'b0;
        exp_q.push_back('{rs: 1'b0, db: 8'h01});
        m_col = 0;
        m_row = 0;
        check_writes("clear");
        chk_eq("clear_fila", 32'(Fila), 32'd0);

        // Row wrap: directed first row, then three random rows.
        for (int i = 0; i < 20; i++) send_char(8'h30 + 8'(i));
        check_writes("row0");
        chk_eq("row0_fila", 32'(Fila), 32'(m_row));
        for (int i = 0; i < 60; i++) begin
            d = 8'($urandom);
            send_char(d);
        end
        check_writes("rows123");
        chk_eq("wrap_fila", 32'(Fila), 32'(m_row));
        check_lista();

        // Clear priority over a simultaneous character.
        for (int i = 0; i < 25; i++) begin
            d = 8'($urandom);
            send_char(d);
        end
        check_writes("pre_clear");
        d = 8'($urandom);
        Limpiar = 1'b1;
        Escribir = 1'b1;
        Dato = d;
        req = cyc;
        tick(1);
        chk_eq("clr_no_lista", 32'(Lista), 32'd0);
        Limpiar = 1'b0;
        exp_q.push_back('{rs: 1'b0, db: 8'h01});
        m_col = 0;
        m_row = 0;
        wait_lista(ok);
        chk_eq("clr_pending_lista", 32'(ok), 32'd1);
        chk_eq("clr_pending_delay", 32'(cyc - req), 32'(TS + TW + TH + TC + 2));
        chk_eq("clr_pending_fila", 32'(Fila), 32'd0);
        if (ok) model_char(d);
        Escribir = 1'b0;
        for (int i = 0; i < 19; i++) begin
            d = 8'($urandom);
            send_char(d);
        end
        check_writes("post_clear");
        chk_eq("post_clear_fila", 32'(Fila), 32'(m_row));

        // Limpiar during PULSE and Escribir during EXEC are both ignored.
        send_char(8'h5A);
        wait_e(ok);
        chk_eq("strobe_seen", 32'(ok), 32'd1);
        Limpiar = 1'b1;
        tick(1);
        Limpiar = 1'b0;
        n0 = lista_q.size();
        tick(6);
        Escribir = 1'b1;
        Dato = 8'hEE;
        tick(1);
        Escribir = 1'b0;
        tick(40);
        chk_eq("no_lista_outside_ready", 32'(lista_q.size()), 32'(n0));
        check_writes("ignored");
        check_lista();
        chk_eq("db_glitch_while_e", 32'(glitch_cnt), 32'd0);
        chk_eq("db_hold_violations", 32'(hold_viol), 32'd0);
        chk_eq("rw_high_samples", 32'(rw_high), 32'd0);

        // Reset in the middle of a strobe.
        d = 8'($urandom);
        send_char(d);
        chk_eq("pre_reset_fila", 32'(Fila), 32'(m_row));
        wait_e(ok);
        chk_eq("strobe_before_reset", 32'(ok), 32'd1);
        Reset = 1'b1;
        #1;
        chk_eq("midrst_e", 32'(LCD_E), 32'd0);
        chk_eq("midrst_init_done", 32'(Init_Done), 32'd0);
        chk_eq("midrst_fila", 32'(Fila), 32'd0);
        tick(3);
        pulse_q.delete();
        exp_q.delete();
        lista_q.delete();
        n_chars = 0;
        do_init_check();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
